// File: rtl/iot_event_tx.sv
// Event transmitter: turns per-device on/off transitions into a serial change/on_off
// event stream, one event per clock, coalesced per device and served round-robin.
module iot_event_tx #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     dev_active_i,
    input  logic             hold_i,
    output logic             change_o,
    output logic             on_off_o,
    output logic [IDX_W-1:0] dev_idx_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] reported_count_o
);

    logic [N-1:0]     dev_q, rep_q, rep_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     pend;
    logic [2*N-1:0]   pend_rot;
    logic             found;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   pos;
    logic [N-1:0]     sel_hot;
    logic             sel_lvl;

    assign pend     = dev_q ^ rep_q;
    assign busy_o   = |pend;
    // Rotating a doubled copy puts the search start (ptr) at bit 0.
    assign pend_rot = {pend, pend} >> ptr_q;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && pend_rot[k]) begin
                found = 1'b1;
                pos   = {1'b0, ptr_q} + (IDX_W+1)'(k);
                if (pos >= (IDX_W+1)'(N)) begin
                    pos = pos - (IDX_W+1)'(N);
                end
                sel = pos[IDX_W-1:0];
            end
        end
    end

    assign sel_hot = N'(1) << sel;
    assign sel_lvl = |(dev_q & sel_hot);

    always_comb begin
        rep_d    = rep_q;
        ptr_d    = ptr_q;
        change_d = 1'b0;
        on_off_d = 1'b0;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        if (!hold_i && found) begin
            // Selected bit is pending, so flipping rep makes it match dev_q.
            rep_d    = rep_q ^ sel_hot;
            ptr_d    = (sel == IDX_W'(N-1)) ? '0 : sel + IDX_W'(1);
            change_d = 1'b1;
            on_off_d = sel_lvl;
            idx_d    = sel;
            cnt_d    = sel_lvl ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_q    <= '0;
            rep_q    <= '0;
            ptr_q    <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            dev_q    <= dev_active_i;
            rep_q    <= rep_d;
            ptr_q    <= ptr_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign change_o         = change_q;
    assign on_off_o         = on_off_q;
    assign dev_idx_o        = idx_q;
    assign reported_count_o = cnt_q;

endmodule

// File: doc/iot_event_tx.md
# iot_event_tx

Event transmitter for the active IoT devices monitor. It watches a vector of per-device activity levels, detects every on/off transition, and serialises them onto the monitor's `change`/`on_off` event interface, one event per clock. Pending transitions are coalesced per device, and devices are served round-robin. It sits between the device status registers and the monitor's counter, and keeps a shadow count of reported-active devices that the monitor's `counter_out` must match.

## Interface
- `N`, 8: number of monitored devices, 2..32.
- `IDX_W`, 3: width of device index, ≥ clog2(N).
- `CNT_W`, 8: width of shadow count, ≥ clog2(N+1).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `dev_active`  in  N  current activity level per device; bit i = 1 means device i is on.
- `hold`  in  1  when 1, no events are emitted and pending transitions accumulate.
- `change`  out  1  one-cycle event strobe to the monitor.
- `on_off`  out  1  event direction, valid with `change`: 1 = device turned on (increment), 0 = turned off (decrement).
- `dev_idx`  out  IDX_W  index of the device for the current event.
- `busy`  out  1  1 while any transition is pending.
- `reported_count`  out  CNT_W  number of devices currently reported on (popcount of `rep`).

## Operation
- State:
  - `dev_q[N]`: registered copy of `dev_active`.
  - `rep[N]`: last reported level per device.
  - `ptr[IDX_W]`: round-robin start index.
- Pending vector is `pend = dev_q ^ rep`, combinational.
- `busy = |pend`, combinational from registers.
- Every rising edge: `dev_q <= dev_active`.
- Same edge, if `hold==0` and `pend!=0`:
  - Select i = first set bit of `pend` searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Drive `change<=1`, `on_off<=dev_q[i]`, `dev_idx<=i`.
  - Update `rep[i]<=dev_q[i]`.
  - Set `ptr<=(i+1) mod N`.
  - Update `reported_count` by +1 if `dev_q[i]` else -1.
- Otherwise: `change<=0`, `on_off<=0`; `dev_idx`, `ptr`, `rep` and `reported_count` hold.
- The event always carries the level held in `dev_q` at selection time.
- Coalescing: a device that returns to its reported level before being served drops out of `pend` and produces no event. A pending on→off→on sequence yields at most one event.
- `reported_count` always equals popcount(`rep`). It never wraps because it stays in 0..N.
- Pulses on `dev_active` shorter than one clock, between sampling edges, are not seen. This is intended.
- `hold` does not affect sampling. When `hold` falls, serving resumes from the current `ptr`.
- Reset (async, any time, including mid-burst):
  - `dev_q`, `rep`, `ptr`: 0.
  - `change`, `on_off`, `dev_idx`, `reported_count`: 0.
  - Devices on at reset release are reported as new on-events. The monitor is reset on the same reset.

## Timing
- Input level change before edge k is captured in `dev_q` at edge k. Its event is registered at edge k+1, with `change` high for the cycle after k+1.
- Uncontended latency is 2 clocks from input to the `change` strobe.
- `change` is high for exactly one cycle per event. Back-to-back events are consecutive cycles with `change` staying high and `dev_idx` and `on_off` updating each cycle.
- Throughput is 1 event/clock. A burst of M simultaneous transitions completes in M cycles. A device waits at most N-1 events behind others.
- `reported_count` and `rep` update on the same edge that raises `change`. The monitor's count reflects the event one edge later.
- `busy` falls in the cycle after the last event's edge, when `pend` becomes 0.
- Reset removal: the first sampling edge is the first rising edge with `rst==1`.

## Test plan
- Reset: `rst=0` mid-cycle with `dev_active=8'hFF` -> immediately `change=0`, `on_off=0`, `dev_idx=0`, `reported_count=0`, `busy=0`; after release, 8 on-events follow with idx 0..7.
- Single device: from idle with all devices off, set `dev_active=8'h08` -> 2 edges later `change=1`, `on_off=1`, `dev_idx=3` for one cycle, `reported_count=1`; then clear bit 3 -> one event with `on_off=0`, `dev_idx=3`, count 0.
- Burst/round-robin: `ptr=5` (after serving idx 4), set `dev_active=8'hFF` -> 8 consecutive `change` cycles with idx 5,6,7,0,1,2,3,4, count steps 1..8, then `busy=0`.
- Coalesce under hold: `hold=1`, set bit 2 then clear it 3 cycles later, release `hold` -> no event, `reported_count` unchanged, `busy` low after bit clears.
- Hold accumulate: `hold=1`, set `dev_active=8'h81` -> no `change`, `busy=1`; release -> two events (idx 0, 7, `on_off=1`), count 2.
- Reset mid-burst: assert `rst` after 3 of 8 burst events -> outputs 0 immediately; after release, 8 fresh on-events and final count 8 (bench cross-checks against the monitor's `counter_out`).
